// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants and state encoding for the 8-way mux arbiter.
package mux_ctrl_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Requester/consumer bundle; master drives requests and ready, slave is the arbiter.
interface mux8_rr_arbiter_if #(
  parameter int unsigned DW = 1
);
  import mux_ctrl_pkg::*;

  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    last;
  logic [N_REQ*DW-1:0] din;
  logic                out_ready;
  logic                out_valid;
  logic [DW-1:0]       out_data;
  logic [SEL_W-1:0]    sel;
  logic [N_REQ-1:0]    gnt;
  logic                busy;

  modport master (
    output req, last, din, out_ready,
    input  out_valid, out_data, sel, gnt, busy
  );

  modport slave (
    input  req, last, din, out_ready,
    output out_valid, out_data, sel, gnt, busy
  );

endinterface

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Round-robin pick: first set request at or after ptr, wrapping 7->0.
module rr_pick8
  import mux_ctrl_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   off;

  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N_REQ-1:0];
    off = '0;
    // Descending scan so the lowest set bit of the rotated vector wins.
    for (int unsigned i = N_REQ; i > 0; i--) begin
      if (rot[SEL_W'(i - 1)]) off = SEL_W'(i - 1);
    end
    found = |rot;
    idx   = off + ptr;
  end

endmodule

// File: rtl/mux_8to1.sv
// Single-bit 8:1 mux from the existing datapath library.
module mux_8to1 (
  input  logic [7:0] d,
  input  logic [2:0] sel,
  output logic       y
);

  assign y = d[sel];

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sequencing one requester's beats onto a shared valid/ready channel.
module mux8_rr_arbiter
  import mux_ctrl_pkg::*;
#(
  parameter int unsigned DW       = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input logic         clk,
  input logic         rst_n,
  mux8_rr_arbiter_if.slave bus
);

  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             found;
  logic [SEL_W-1:0] idx;
  logic             valid;
  logic             accept;
  logic [DW-1:0]    data_mux;

  rr_pick8 u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .found (found),
    .idx   (idx)
  );

  assign valid  = (state_q == ST_XFER) && bus.req[sel_q];
  assign accept = valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d    = ST_XFER;
          sel_d      = idx;
          gnt_d      = '0;
          gnt_d[idx] = 1'b1;
          cnt_d      = '0;
        end
      end
      ST_XFER: begin
        // Withdrawal, last beat and hold limit share one exit so they never double count.
        if (!bus.req[sel_q] ||
            (accept && (bus.last[sel_q] || (cnt_q + 4'd1 == HOLD_LIM)))) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q + 3'd1;
          cnt_d   = '0;
        end else if (accept) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  for (genvar b = 0; b < DW; b++) begin : g_bit
    logic [N_REQ-1:0] col;
    for (genvar i = 0; i < N_REQ; i++) begin : g_col
      assign col[i] = bus.din[i*DW + b];
    end
    mux_8to1 u_mux (
      .d   (col),
      .sel (sel_q),
      .y   (data_mux[b])
    );
  end

  assign bus.out_valid = valid;
  assign bus.out_data  = data_mux;
  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.busy      = (state_q == ST_XFER);

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter with hand-computed expectations.
module tb_mux8_rr_arbiter;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  mux8_rr_arbiter_if #(.DW(8)) bus ();

  mux8_rr_arbiter #(.DW(8), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.req = '0;
    bus.last = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus.din[i*8 +: 8] = 8'hA0 + 8'(i);

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_sel", bus.sel, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_data", bus.out_data, 32'hA0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_gnt", bus.gnt, 0);
      chk("idle_valid", bus.out_valid, 0);
      chk("idle_busy", bus.busy, 0);
    end

    // single requester, last on third beat
    bus.req = 8'h08;
    bus.out_ready = 1'b1;
    tick();
    chk("single_sel", bus.sel, 3);
    chk("single_gnt", bus.gnt, 32'h08);
    chk("single_valid", bus.out_valid, 1);
    chk("single_data1", bus.out_data, 32'hA3);
    tick();
    chk("single_gnt_b1", bus.gnt, 32'h08);
    chk("single_data2", bus.out_data, 32'hA3);
    tick();
    chk("single_gnt_b2", bus.gnt, 32'h08);
    bus.last = 8'h08;
    tick();
    chk("single_end_gnt", bus.gnt, 0);
    chk("single_end_busy", bus.busy, 0);
    bus.req = '0;
    bus.last = '0;

    // ptr now 4: bits 3 and 4 requested, 4 must win
    bus.req = 8'h18;
    tick();
    chk("ptr4_sel", bus.sel, 4);
    chk("ptr4_gnt", bus.gnt, 32'h10);
    bus.req = '0;
    tick();
    chk("ptr4_wd_gnt", bus.gnt, 0);

    // round robin over all requesters with hold limit 4 and wrap
    do_reset();
    bus.req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      tick();
      chk("rr_sel", bus.sel, g % 8);
      chk("rr_gnt", bus.gnt, 1 << (g % 8));
      chk("rr_data", bus.out_data, 32'hA0 + (g % 8));
      if (g < 8) begin
        for (int b = 0; b < 3; b++) begin
          tick();
          chk("rr_hold_gnt", bus.gnt, 1 << (g % 8));
        end
        tick();
        chk("rr_gap_gnt", bus.gnt, 0);
        chk("rr_gap_busy", bus.busy, 0);
      end
    end
    bus.req = '0;
    tick();
    chk("rr_wd_gnt", bus.gnt, 0);

    // backpressure on requester 5; last while stalled has no effect
    bus.req = 8'h20;
    bus.out_ready = 1'b0;
    tick();
    chk("bp_sel", bus.sel, 5);
    chk("bp_gnt", bus.gnt, 32'h20);
    chk("bp_valid", bus.out_valid, 1);
    bus.last = 8'h20;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp_stall_valid", bus.out_valid, 1);
      chk("bp_stall_sel", bus.sel, 5);
      chk("bp_stall_gnt", bus.gnt, 32'h20);
    end
    bus.last = '0;
    bus.out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      tick();
      chk("bp_run_gnt", bus.gnt, 32'h20);
    end
    tick();
    chk("bp_end_gnt", bus.gnt, 0);
    bus.req = '0;

    // withdrawal of requester 2, then requester 7 granted
    do_reset();
    bus.req = 8'h84;
    tick();
    chk("wd_sel", bus.sel, 2);
    chk("wd_gnt", bus.gnt, 32'h04);
    tick();
    chk("wd_gnt_b1", bus.gnt, 32'h04);
    bus.req = 8'h80;
    #1;
    chk("wd_valid_drop", bus.out_valid, 0);
    tick();
    chk("wd_end_gnt", bus.gnt, 0);
    chk("wd_end_busy", bus.busy, 0);
    tick();
    chk("wd_next_sel", bus.sel, 7);
    chk("wd_next_gnt", bus.gnt, 32'h80);
    chk("wd_next_valid", bus.out_valid, 1);

    // asynchronous reset mid-transfer
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", bus.gnt, 0);
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_sel", bus.sel, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = 8'h01;
    tick();
    chk("arst_regrant_sel", bus.sel, 0);
    chk("arst_regrant_gnt", bus.gnt, 32'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the team's 8-to-1 mux datapath; shares one output channel among 8 requesters.
- Picks one requester, drives the mux select and a one-hot grant, and moves that requester's data beats over a valid/ready output handshake.
- Releases the grant on a last beat, a hold-limit expiry, or request withdrawal.
- Sits between 8 producer blocks and one downstream consumer.

Parameters:
- DW, 1, data width per requester and of out_data.
- MAX_HOLD, 4, max accepted beats per grant (1..15); the grant is forced off after MAX_HOLD beats.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  8  request per requester; req[i] held high while requester i has data.
- last  in  8  last[i] marks requester i's current beat as final.
- din  in  8*DW  packed data; requester i's data is din[i*DW +: DW].
- out_ready  in  1  downstream can accept a beat.
- out_valid  out  1  beat available on out_data.
- out_data  out  DW  muxed data, equal to din[sel].
- sel  out  3  mux select, index of the granted requester.
- gnt  out  8  one-hot grant; all zero when idle.
- busy  out  1  high in XFER state.

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE, gnt=0, sel=0, ptr=0, beat_cnt=0, busy=0. out_valid=0 and out_data=din[0] combinationally.
- States: IDLE, XFER.
- IDLE, with any req bit high:
  - Search req starting at index ptr, ascending, wrapping 7->0. The first set index w wins.
  - Next edge: sel<=w, gnt<=1<<w, beat_cnt<=0, state<=XFER.
  - Latency: req rising at edge t is granted at edge t+1.
- IDLE, with req==0: stay in IDLE.
- XFER outputs:
  - out_valid = req[sel] (combinational).
  - out_data = din[sel] (combinational).
  - A beat is accepted when out_valid && out_ready at a rising edge; beat_cnt increments on accept.
- XFER ends at the edge where any of these holds:
  - (a) a beat is accepted with last[sel]=1;
  - (b) a beat is accepted and beat_cnt+1==MAX_HOLD;
  - (c) req[sel]==0 (withdrawal, no accept).
- On end: state<=IDLE, gnt<=0, ptr<=(sel+1) mod 8, beat_cnt<=0. sel holds its value.
- Exactly one IDLE cycle always separates consecutive grants. No back-to-back grant.
- With out_ready low in XFER: hold state, sel, gnt and beat_cnt; the beat stays presented.
- Other req bits changing during XFER: ignored until IDLE.
- last[sel] high while out_ready is low: no effect until the beat is accepted.
- (a) and (b) in the same cycle: a single end, no double count.
- ptr wrap: after a grant to 7, the next search starts at 0.
- Reset asserted mid-XFER: outputs return to reset values immediately. A partial transaction is dropped and ptr returns to 0.
- beat_cnt width is 4 bits.

Decomposition:
- Shared package mux_ctrl_pkg holds:
  - state encodings ST_IDLE=1'b0, ST_XFER=1'b1;
  - constant N_REQ=8;
  - select width SEL_W=3.
- One combinational sub-module, rr_pick8:
  - inputs req[7:0] and ptr[2:0];
  - outputs found (1) and idx[2:0];
  - rotates req by ptr, priority-encodes lowest set bit, adds ptr mod 8.
- The 8:1 data mux is instantiated from the existing mux_8to1 design, one instance per data bit, driven by sel.

Test Plan:
- Reset/idle: rst_n=0, then release with req=0 -> gnt=0, out_valid=0 and busy=0 for 5 cycles.
- Single requester: req=8'h08, last[3] high on 3rd beat, out_ready=1 -> sel=3 and gnt=8'h08 one edge after req; out_data equals din[3] on each beat; 3 beats accepted; gnt=0 next edge; ptr=4.
- Round-robin fairness, wrap and hold limit:
  - req=8'hFF held, last=0, out_ready=1, MAX_HOLD=4 -> grant order 0,1,2,...,7,0.
  - Each grant lasts exactly 4 beats.
  - One idle cycle between grants.
- Backpressure: grant to 5, out_ready=0 for 6 cycles, then 1 -> out_valid stays 1, sel=5, no beat_cnt change; the transfer completes after out_ready returns.
- Withdrawal:
  - Granted to 2 with req=8'h84; drop req[2] after 1 beat.
  - Expect gnt=0 on the next edge, then gnt=8'h80 (sel=7) one edge later.
- Async reset mid-transfer: assert rst_n=0 between edges during XFER -> gnt=0 and out_valid=0 immediately; after release, req=8'h01 is granted to 0.
